// File: rtl/sram22_rr_port_ctrl_pkg.sv
// Shared types and constants for the SRAM22 round-robin port controller.
package sram22_ctrl_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF  = 6;
    localparam int WMASK_WIDTH_DEF = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // One stage of the read-response tag pipeline.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/sram22_rr_port_ctrl_if.sv
// Requester handshakes, macro pins and busy flag of the SRAM22 port controller.
interface sram22_rr_port_ctrl_if
    import sram22_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int WMASK_WIDTH = WMASK_WIDTH_DEF
);
    logic                   a_req_valid;
    logic                   a_req_ready;
    logic                   a_req_we;
    logic [ADDR_WIDTH-1:0]  a_req_addr;
    logic [DATA_WIDTH-1:0]  a_req_wdata;
    logic [WMASK_WIDTH-1:0] a_req_wmask;
    logic                   a_rsp_valid;
    logic [DATA_WIDTH-1:0]  a_rsp_rdata;

    logic                   b_req_valid;
    logic                   b_req_ready;
    logic                   b_req_we;
    logic [ADDR_WIDTH-1:0]  b_req_addr;
    logic [DATA_WIDTH-1:0]  b_req_wdata;
    logic [WMASK_WIDTH-1:0] b_req_wmask;
    logic                   b_rsp_valid;
    logic [DATA_WIDTH-1:0]  b_rsp_rdata;

    logic                   sram_we;
    logic [WMASK_WIDTH-1:0] sram_wmask;
    logic [ADDR_WIDTH-1:0]  sram_addr;
    logic [DATA_WIDTH-1:0]  sram_din;
    logic [DATA_WIDTH-1:0]  sram_dout;
    logic                   busy;

    modport slave (
        input  a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_wmask,
        input  b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_wmask,
        input  sram_dout,
        output a_req_ready, a_rsp_valid, a_rsp_rdata,
        output b_req_ready, b_rsp_valid, b_rsp_rdata,
        output sram_we, sram_wmask, sram_addr, sram_din, busy
    );

    modport master (
        output a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_wmask,
        output b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_wmask,
        output sram_dout,
        input  a_req_ready, a_rsp_valid, a_rsp_rdata,
        input  b_req_ready, b_rsp_valid, b_rsp_rdata,
        input  sram_we, sram_wmask, sram_addr, sram_din, busy
    );

endinterface

// File: rtl/sram22_rr_port_ctrl_arb2.sv
// Two-way round-robin arbiter; the pointer names the side that wins a tie
// and flips only when both sides competed.
module sram22_rr_arb2
    import sram22_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rstb,
    input  logic i_run,
    input  logic i_validA,
    input  logic i_validB,
    output logic o_grantA,
    output logic o_grantB
);
    logic r_ptr;

    always_comb begin
        o_grantA = 1'b0;
        o_grantB = 1'b0;
        if (i_run) begin
            if (i_validA && i_validB) begin
                o_grantA = (r_ptr == ID_A);
                o_grantB = (r_ptr == ID_B);
            end else begin
                o_grantA = i_validA;
                o_grantB = i_validB;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_ptr <= ID_A;
        end else if (i_run && i_validA && i_validB) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule

// File: rtl/sram22_rr_port_ctrl.sv
// Round-robin controller sharing one SRAM22 macro between requesters A and B.
// Define SRAM_RR_INIT_EN to zero the whole array with a sweep after every reset.
module sram22_rr_port_ctrl
    import sram22_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int WMASK_WIDTH = WMASK_WIDTH_DEF
) (
    input logic clk,
    input logic rstb,
    sram22_rr_port_ctrl_if.slave bus
);
    state_t                 r_state;
    tag_t                   r_tag0;
    tag_t                   r_tag1;
    logic                   r_sramWe;
    logic [WMASK_WIDTH-1:0] r_sramWmask;
    logic [ADDR_WIDTH-1:0]  r_sramAddr;
    logic [DATA_WIDTH-1:0]  r_sramDin;

    logic                   w_run;
    logic                   w_grantA;
    logic                   w_grantB;
    logic                   w_hs;
    logic                   w_selWe;
    logic [WMASK_WIDTH-1:0] w_selWmask;
    logic [ADDR_WIDTH-1:0]  w_selAddr;
    logic [DATA_WIDTH-1:0]  w_selWdata;
    logic                   w_rspA;
    logic                   w_rspB;

`ifdef SRAM_RR_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_initAddr;
    assign bus.busy = r_busy;
`else
    localparam state_t RESET_STATE = ST_RUN;
    assign bus.busy = 1'b0;
`endif

    assign w_run = (r_state == ST_RUN);

    sram22_rr_arb2 u_arb (
        .clk      (clk),
        .rstb     (rstb),
        .i_run    (w_run),
        .i_validA (bus.a_req_valid),
        .i_validB (bus.b_req_valid),
        .o_grantA (w_grantA),
        .o_grantB (w_grantB)
    );

    assign bus.a_req_ready = w_run && w_grantA;
    assign bus.b_req_ready = w_run && w_grantB;
    assign w_hs = (bus.a_req_valid && bus.a_req_ready) || (bus.b_req_valid && bus.b_req_ready);

    assign w_selWe    = w_grantB ? bus.b_req_we    : bus.a_req_we;
    assign w_selWmask = w_grantB ? bus.b_req_wmask : bus.a_req_wmask;
    assign w_selAddr  = w_grantB ? bus.b_req_addr  : bus.a_req_addr;
    assign w_selWdata = w_grantB ? bus.b_req_wdata : bus.a_req_wdata;

    // Idle cycles deassert the write enable but leave the other pins parked.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= RESET_STATE;
            r_sramWe    <= 1'b0;
            r_sramWmask <= '0;
            r_sramAddr  <= '0;
            r_sramDin   <= '0;
            r_tag0      <= '0;
            r_tag1      <= '0;
`ifdef SRAM_RR_INIT_EN
            r_busy      <= 1'b1;
            r_initAddr  <= '0;
`endif
        end else begin
            r_tag1   <= r_tag0;
            r_tag0   <= '0;
            r_sramWe <= 1'b0;
`ifdef SRAM_RR_INIT_EN
            if (r_state == ST_INIT) begin
                r_sramWe    <= 1'b1;
                r_sramWmask <= '1;
                r_sramAddr  <= r_initAddr;
                r_sramDin   <= '0;
                r_initAddr  <= r_initAddr + 1'b1;
                if (r_initAddr == '1) begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            end else
`endif
            if (w_hs) begin
                r_sramWe    <= w_selWe;
                r_sramWmask <= w_selWmask;
                r_sramAddr  <= w_selAddr;
                r_sramDin   <= w_selWdata;
                r_tag0      <= '{valid: !w_selWe, id: (w_grantB ? ID_B : ID_A)};
            end
        end
    end

    assign bus.sram_we    = r_sramWe;
    assign bus.sram_wmask = r_sramWmask;
    assign bus.sram_addr  = r_sramAddr;
    assign bus.sram_din   = r_sramDin;

    // The macro's registered output lines up with the second tag stage.
    assign w_rspA = r_tag1.valid && (r_tag1.id == ID_A);
    assign w_rspB = r_tag1.valid && (r_tag1.id == ID_B);

    assign bus.a_rsp_valid = w_rspA;
    assign bus.b_rsp_valid = w_rspB;
    assign bus.a_rsp_rdata = w_rspA ? bus.sram_dout : '0;
    assign bus.b_rsp_rdata = w_rspB ? bus.sram_dout : '0;

endmodule

// File: tb/tb_sram22_rr_port_ctrl.sv
// Self-checking bench for sram22_rr_port_ctrl: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_sram22_rr_port_ctrl;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic        m;
    } req_t;

    typedef struct packed {
        req_t        a;
        req_t        b;
        logic        rdyA;
        logic        rdyB;
        logic        rspA;
        logic        rspB;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } exp_t;

`ifdef SRAM_RR_INIT_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstb;
    logic preload = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    logic [31:0] mem [64];
    logic [31:0] gold [64];
    exp_t        expQ [$];
    logic        favourB;
    vec_t        tbl [14];

    sram22_rr_port_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WMASK_WIDTH(1)) busIf ();

    sram22_rr_port_ctrl u_dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (busIf.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural single-port macro: one registered read or masked write per edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (busIf.sram_we) begin
            if (busIf.sram_wmask[0]) mem[busIf.sram_addr] <= busIf.sram_din;
        end else begin
            busIf.sram_dout <= mem[busIf.sram_addr];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic req_t mkReq(input logic v, input logic we, input logic [5:0] addr,
                                   input logic [31:0] wd, input logic m);
        req_t r;
        r.v = v; r.we = we; r.addr = addr; r.wd = wd; r.m = m;
        return r;
    endfunction

    function automatic vec_t mkVec(input req_t a, input req_t b, input logic rdyA, input logic rdyB,
                                   input logic rspA, input logic rspB, input logic [31:0] data);
        vec_t t;
        t.a = a; t.b = b; t.rdyA = rdyA; t.rdyB = rdyB; t.rspA = rspA; t.rspB = rspB; t.data = data;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setInputs(input req_t a, input req_t b);
        busIf.a_req_valid = a.v;
        busIf.a_req_we    = a.we;
        busIf.a_req_addr  = a.addr;
        busIf.a_req_wdata = a.wd;
        busIf.a_req_wmask = a.m;
        busIf.b_req_valid = b.v;
        busIf.b_req_we    = b.we;
        busIf.b_req_addr  = b.addr;
        busIf.b_req_wdata = b.wd;
        busIf.b_req_wmask = b.m;
    endtask

    // Caller is at a negedge; reset is held two cycles, then any init sweep is watched.
    task automatic doReset();
        int cnt;
        int ok;
        setInputs(mkReq(0, 0, 0, 0, 0), mkReq(0, 0, 0, 0, 0));
        rstb = 1'b0;
        #1;
        checkOutput("rst_sram_we", busIf.sram_we, 0);
        checkOutput("rst_sram_wmask", busIf.sram_wmask, 0);
        checkOutput("rst_sram_addr", busIf.sram_addr, 0);
        checkOutput("rst_sram_din", busIf.sram_din, 0);
        checkOutput("rst_ready_a", busIf.a_req_ready, 0);
        checkOutput("rst_ready_b", busIf.b_req_ready, 0);
        checkOutput("rst_rsp_valid_a", busIf.a_rsp_valid, 0);
        checkOutput("rst_rsp_valid_b", busIf.b_rsp_valid, 0);
        checkOutput("rst_rsp_rdata_a", busIf.a_rsp_rdata, 0);
        checkOutput("rst_busy", busIf.busy, EXP_BUSY_RST);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        expQ.delete();
        favourB = 1'b0;
`ifdef SRAM_RR_INIT_EN
        for (int i = 0; i < 64; i++) gold[i] = 32'h0;
        setInputs(mkReq(1, 0, 0, 0, 0), mkReq(1, 0, 6'd63, 0, 0));
        cnt = 0;
        ok = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (busIf.sram_we === 1'b1 && busIf.sram_addr === 6'(cnt - 1) &&
                busIf.sram_din === 32'h0 && busIf.sram_wmask === 1'b1 &&
                busIf.a_rsp_valid === 1'b0 && busIf.b_rsp_valid === 1'b0 &&
                (busIf.busy === 1'b0 || (busIf.a_req_ready === 1'b0 && busIf.b_req_ready === 1'b0)))
                ok++;
        end while (busIf.busy !== 1'b0 && cnt < 200);
        setInputs(mkReq(0, 0, 0, 0, 0), mkReq(0, 0, 0, 0, 0));
        checkOutput("init_busy_cycles", cnt, 64);
        checkOutput("init_sweep_cycles_ok", ok, 64);
`endif
    endtask

    // One model-checked cycle: compare responses and grants against the reference.
    task automatic applyStimulus(input req_t a, input req_t b);
        logic        expA;
        logic        expB;
        logic [31:0] expD;
        logic        winA;
        logic        winB;
        req_t        w;
        exp_t        e;
        @(negedge clk);
        expA = 1'b0;
        expB = 1'b0;
        expD = 32'h0;
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            e = expQ.pop_front();
            expA = (e.id == 1'b0);
            expB = (e.id == 1'b1);
            expD = e.data;
        end
        checkOutput("rnd_rsp_valid_a", busIf.a_rsp_valid, expA);
        checkOutput("rnd_rsp_valid_b", busIf.b_rsp_valid, expB);
        if (expA) checkOutput("rnd_rsp_rdata_a", busIf.a_rsp_rdata, expD);
        if (expB) checkOutput("rnd_rsp_rdata_b", busIf.b_rsp_rdata, expD);
        setInputs(a, b);
        #1;
        winA = a.v && (!b.v || !favourB);
        winB = b.v && (!a.v || favourB);
        checkOutput("rnd_ready_a", busIf.a_req_ready, winA);
        checkOutput("rnd_ready_b", busIf.b_req_ready, winB);
        if (a.v && b.v) favourB = !favourB;
        if (winA || winB) begin
            w = winA ? a : b;
            if (w.we) begin
                if (w.m) gold[w.addr] = w.wd;
            end else begin
                e.id = winB;
                e.data = gold[w.addr];
                e.due = cyc + 2;
                expQ.push_back(e);
            end
        end
    endtask

    initial begin
        req_t idle;
        req_t wrA1;
        req_t wrB2;
        req_t rdA1;
        req_t rdB2;
        idle = mkReq(0, 0, 0, 0, 0);
        wrA1 = mkReq(1, 1, 6'd1, 32'hA1A1_A1A1, 1);
        wrB2 = mkReq(1, 1, 6'd2, 32'hB2B2_B2B2, 1);
        rdA1 = mkReq(1, 0, 6'd1, 0, 0);
        rdB2 = mkReq(1, 0, 6'd2, 0, 0);
        tbl[0]  = mkVec(wrA1, wrB2, 1, 0, 0, 0, 32'h0);
        tbl[1]  = mkVec(wrA1, wrB2, 0, 1, 0, 0, 32'h0);
        tbl[2]  = mkVec(rdA1, rdB2, 1, 0, 0, 0, 32'h0);
        tbl[3]  = mkVec(rdA1, rdB2, 0, 1, 0, 0, 32'h0);
        tbl[4]  = mkVec(rdA1, rdB2, 1, 0, 1, 0, 32'hA1A1_A1A1);
        tbl[5]  = mkVec(rdA1, rdB2, 0, 1, 0, 1, 32'hB2B2_B2B2);
        tbl[6]  = mkVec(idle, rdB2, 0, 1, 1, 0, 32'hA1A1_A1A1);
        tbl[7]  = mkVec(idle, rdB2, 0, 1, 0, 1, 32'hB2B2_B2B2);
        tbl[8]  = mkVec(idle, rdB2, 0, 1, 0, 1, 32'hB2B2_B2B2);
        tbl[9]  = mkVec(rdA1, rdB2, 1, 0, 0, 1, 32'hB2B2_B2B2);
        tbl[10] = mkVec(rdA1, rdB2, 0, 1, 0, 1, 32'hB2B2_B2B2);
        tbl[11] = mkVec(idle, idle, 0, 0, 1, 0, 32'hA1A1_A1A1);
        tbl[12] = mkVec(idle, idle, 0, 0, 0, 1, 32'hB2B2_B2B2);
        tbl[13] = mkVec(idle, idle, 0, 0, 0, 0, 32'h0);

        rstb = 1'b1;
        setInputs(idle, idle);
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        doReset();

        // Write then read back on A with exact response latency.
        @(negedge clk);
        setInputs(mkReq(1, 1, 6'd5, 32'hDEAD_BEEF, 1), idle);
        #1 checkOutput("t1_wr_ready", busIf.a_req_ready, 1);
        @(negedge clk);
        checkOutput("t1_pin_we", busIf.sram_we, 1);
        checkOutput("t1_pin_addr", busIf.sram_addr, 5);
        checkOutput("t1_pin_din", busIf.sram_din, 32'hDEAD_BEEF);
        setInputs(mkReq(1, 0, 6'd5, 0, 0), idle);
        #1 checkOutput("t1_rd_ready", busIf.a_req_ready, 1);
        @(negedge clk);
        setInputs(idle, idle);
        checkOutput("t1_rsp_early", busIf.a_rsp_valid, 0);
        checkOutput("t1_rd_pin_we", busIf.sram_we, 0);
        @(negedge clk);
        checkOutput("t1_rsp_valid", busIf.a_rsp_valid, 1);
        checkOutput("t1_rsp_rdata", busIf.a_rsp_rdata, 32'hDEAD_BEEF);
        checkOutput("t1_rsp_b_quiet", busIf.b_rsp_valid, 0);
        checkOutput("t1_idle_we", busIf.sram_we, 0);
        checkOutput("t1_idle_addr_held", busIf.sram_addr, 5);
        @(negedge clk);
        checkOutput("t1_rsp_once", busIf.a_rsp_valid, 0);

        // A masked-off write must leave the stored word intact.
        @(negedge clk);
        setInputs(mkReq(1, 1, 6'd9, 32'h1234_5678, 1), idle);
        @(negedge clk);
        setInputs(mkReq(1, 1, 6'd9, 32'hFFFF_0000, 0), idle);
        @(negedge clk);
        checkOutput("t4_pin_wmask", busIf.sram_wmask, 0);
        setInputs(mkReq(1, 0, 6'd9, 0, 0), idle);
        @(negedge clk);
        setInputs(idle, idle);
        @(negedge clk);
        checkOutput("t4_rsp_valid", busIf.a_rsp_valid, 1);
        checkOutput("t4_rsp_rdata", busIf.a_rsp_rdata, 32'h1234_5678);

        @(negedge clk);
        doReset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            setInputs(tbl[i].a, tbl[i].b);
            #1;
            checkOutput($sformatf("tbl%0d_ready_a", i), busIf.a_req_ready, tbl[i].rdyA);
            checkOutput($sformatf("tbl%0d_ready_b", i), busIf.b_req_ready, tbl[i].rdyB);
            checkOutput($sformatf("tbl%0d_rsp_valid_a", i), busIf.a_rsp_valid, tbl[i].rspA);
            checkOutput($sformatf("tbl%0d_rsp_valid_b", i), busIf.b_rsp_valid, tbl[i].rspB);
            if (tbl[i].rspA) checkOutput($sformatf("tbl%0d_rdata_a", i), busIf.a_rsp_rdata, tbl[i].data);
            if (tbl[i].rspB) checkOutput($sformatf("tbl%0d_rdata_b", i), busIf.b_rsp_rdata, tbl[i].data);
        end

        // Reset with a read in flight must drop its response.
        @(negedge clk);
        setInputs(mkReq(1, 0, 6'd5, 0, 0), idle);
        #1 checkOutput("t5_rd_ready", busIf.a_req_ready, 1);
        @(negedge clk);
        doReset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_no_rsp_a_%0d", i), busIf.a_rsp_valid, 0);
            checkOutput($sformatf("t5_no_rsp_b_%0d", i), busIf.b_rsp_valid, 0);
        end

        for (int i = 0; i < 64; i++)
            applyStimulus(mkReq(1, 1, i[5:0], $urandom, 1), idle);
        for (int i = 0; i < 400; i++) begin
            req_t ra;
            req_t rb;
            ra = mkReq(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                       6'($urandom_range(0, 63)), $urandom, ($urandom_range(0, 3) != 0));
            rb = mkReq(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                       6'($urandom_range(0, 63)), $urandom, ($urandom_range(0, 3) != 0));
            applyStimulus(ra, rb);
        end
        repeat (3) applyStimulus(idle, idle);
        checkOutput("rnd_queue_drained", expQ.size(), 0);

`ifdef SRAM_RR_INIT_EN
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        doReset();
        applyStimulus(mkReq(1, 0, 6'd0, 0, 0), idle);
        applyStimulus(idle, mkReq(1, 0, 6'd63, 0, 0));
        repeat (3) applyStimulus(idle, idle);
        checkOutput("t6_queue_drained", expQ.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
